// File: rtl/xvec2_md_requester.sv
// xvec2_md_requester
//   Pipeline-side initiator for the xvec2 vector multiply/divide unit. Takes
//   one decoded RV32M instruction from execute, turns funct3 into the unit's
//   op / output-select / operand-signedness fields, issues it over the
//   req_valid/req_ready handshake, captures the single-cycle response and
//   hands the result to writeback under valid/ready. Handles pipeline kill
//   and a response watchdog.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   issue_*               instruction from execute (valid/ready handshake)
//   kill                  pipeline flush, abandons the current instruction
//   md_req_*              request channel to the unit
//   md_resp_*             response pulse from the unit (no back-pressure)
//   wb_*                  result channel to writeback (valid/ready handshake)
//   busy                  high whenever an instruction is in flight
//   timeout_err           sticky watchdog flag, cleared only by reset

`ifndef VEC_XPR_LEN
`define VEC_XPR_LEN 64
`endif
`ifndef MD_OP_WIDTH
`define MD_OP_WIDTH 2
`endif
`ifndef MD_OUT_SEL_WIDTH
`define MD_OUT_SEL_WIDTH 2
`endif
`ifndef MD_OP_MUL
`define MD_OP_MUL 2'd0
`endif
`ifndef MD_OP_DIV
`define MD_OP_DIV 2'd1
`endif
`ifndef MD_OP_REM
`define MD_OP_REM 2'd2
`endif
`ifndef MD_OUT_LO
`define MD_OUT_LO 2'd0
`endif
`ifndef MD_OUT_HI
`define MD_OUT_HI 2'd1
`endif
`ifndef MD_OUT_REM
`define MD_OUT_REM 2'd2
`endif

module xvec2_md_requester #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_WIDTH      = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [2:0]                   issue_funct3,
    input  logic [`VEC_XPR_LEN-1:0]      issue_rs1,
    input  logic [`VEC_XPR_LEN-1:0]      issue_rs2,
    input  logic [TAG_WIDTH-1:0]         issue_tag,
    input  logic                         kill,
    output logic                         md_req_valid,
    input  logic                         md_req_ready,
    output logic [`MD_OP_WIDTH-1:0]      md_req_op,
    output logic [`MD_OUT_SEL_WIDTH-1:0] md_req_out_sel,
    output logic                         md_req_in_1_signed,
    output logic                         md_req_in_2_signed,
    output logic [`VEC_XPR_LEN-1:0]      md_req_in_1,
    output logic [`VEC_XPR_LEN-1:0]      md_req_in_2,
    input  logic                         md_resp_valid,
    input  logic [`VEC_XPR_LEN-1:0]      md_resp_result,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [`VEC_XPR_LEN-1:0]      wb_result,
    output logic [TAG_WIDTH-1:0]         wb_tag,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic [`MD_OP_WIDTH-1:0]      op;
        logic [`MD_OUT_SEL_WIDTH-1:0] out_sel;
        logic                         s1;
        logic                         s2;
    } dec_t;

    function automatic dec_t decode(input logic [2:0] f3);
        dec_t d;
        case (f3)
            3'd0:    d = '{`MD_OP_MUL, `MD_OUT_LO,  1'b0, 1'b0};
            3'd1:    d = '{`MD_OP_MUL, `MD_OUT_HI,  1'b1, 1'b1};
            3'd2:    d = '{`MD_OP_MUL, `MD_OUT_HI,  1'b1, 1'b0};
            3'd3:    d = '{`MD_OP_MUL, `MD_OUT_HI,  1'b0, 1'b0};
            3'd4:    d = '{`MD_OP_DIV, `MD_OUT_LO,  1'b1, 1'b1};
            3'd5:    d = '{`MD_OP_DIV, `MD_OUT_LO,  1'b0, 1'b0};
            3'd6:    d = '{`MD_OP_REM, `MD_OUT_REM, 1'b1, 1'b1};
            default: d = '{`MD_OP_REM, `MD_OUT_REM, 1'b0, 1'b0};
        endcase
        return d;
    endfunction

    state_t            state;
    dec_t              dec_q;
    logic              discard;
    logic [CNT_W-1:0]  wd_cnt;

    assign issue_ready        = (state == S_IDLE);
    assign md_req_valid       = (state == S_REQ);
    assign wb_valid           = (state == S_WB);
    assign busy               = (state != S_IDLE);
    assign md_req_op          = dec_q.op;
    assign md_req_out_sel     = dec_q.out_sel;
    assign md_req_in_1_signed = dec_q.s1;
    assign md_req_in_2_signed = dec_q.s2;

    // Operand and decode registers carry data only; they are loaded on issue
    // and need no reset because md_req_valid gates them.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && issue_valid && !kill) begin
            md_req_in_1 <= issue_rs1;
            md_req_in_2 <= issue_rs2;
            dec_q       <= decode(issue_funct3);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            timeout_err <= 1'b0;
            wb_result   <= '0;
            wb_tag      <= '0;
            discard     <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A stray response here belongs to nothing and is dropped.
                    if (issue_valid && !kill) begin
                        wb_tag <= issue_tag;
                        state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Once the unit has taken the request it will respond, so
                    // a kill on the handshake cycle must still wait it out.
                    if (md_req_ready) begin
                        state   <= S_WAIT;
                        wd_cnt  <= '0;
                        discard <= kill;
                    end else if (kill) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (md_resp_valid) begin
                        wb_result <= md_resp_result;
                        state     <= (discard || kill) ? S_IDLE : S_WB;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (kill) discard <= 1'b1;
                    end
                end
                S_WB: begin
                    // kill and wb_ready both retire the slot; kill simply
                    // means writeback never saw a completed handshake.
                    if (kill || wb_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xvec2_md_requester.sv
`ifndef VEC_XPR_LEN
`define VEC_XPR_LEN 64
`endif
`ifndef MD_OP_WIDTH
`define MD_OP_WIDTH 2
`endif
`ifndef MD_OUT_SEL_WIDTH
`define MD_OUT_SEL_WIDTH 2
`endif

module tb_xvec2_md_requester;

  localparam int TW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         reset;
  logic                         issue_valid;
  logic                         issue_ready;
  logic [2:0]                   issue_funct3;
  logic [`VEC_XPR_LEN-1:0]      issue_rs1;
  logic [`VEC_XPR_LEN-1:0]      issue_rs2;
  logic [TW-1:0]                issue_tag;
  logic                         kill;
  logic                         md_req_valid;
  logic                         md_req_ready;
  logic [`MD_OP_WIDTH-1:0]      md_req_op;
  logic [`MD_OUT_SEL_WIDTH-1:0] md_req_out_sel;
  logic                         md_req_in_1_signed;
  logic                         md_req_in_2_signed;
  logic [`VEC_XPR_LEN-1:0]      md_req_in_1;
  logic [`VEC_XPR_LEN-1:0]      md_req_in_2;
  logic                         md_resp_valid = 1'b0;
  logic [`VEC_XPR_LEN-1:0]      md_resp_result;
  logic                         wb_valid;
  logic                         wb_ready;
  logic [`VEC_XPR_LEN-1:0]      wb_result;
  logic [TW-1:0]                wb_tag;
  logic                         busy;
  logic                         timeout_err;

  xvec2_md_requester #(.TIMEOUT_CYCLES(64), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_funct3(issue_funct3), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_tag(issue_tag), .kill(kill),
    .md_req_valid(md_req_valid), .md_req_ready(md_req_ready),
    .md_req_op(md_req_op), .md_req_out_sel(md_req_out_sel),
    .md_req_in_1_signed(md_req_in_1_signed),
    .md_req_in_2_signed(md_req_in_2_signed),
    .md_req_in_1(md_req_in_1), .md_req_in_2(md_req_in_2),
    .md_resp_valid(md_resp_valid), .md_resp_result(md_resp_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .wb_tag(wb_tag), .busy(busy), .timeout_err(timeout_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unit model: responds 34 cycles after an accepted request, or never when
  // silent; inject forces one stray response pulse. Reset clears it.
  logic silent = 1'b0;
  logic inject = 1'b0;
  logic hs_s;
  logic rst_s;
  int   cnt = 0;
  always begin
    @(posedge clk);
    hs_s  = md_req_valid && md_req_ready;
    rst_s = reset;
    #1;
    md_resp_valid = 1'b0;
    if (!rst_s) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) md_resp_valid = 1'b1;
      end
      if (hs_s && !silent) cnt = 33;
      if (inject) md_resp_valid = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents one instruction in the current cycle; returns in the next one.
  task automatic issue(input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] b, input logic [TW-1:0] t);
    issue_valid  = 1'b1;
    issue_funct3 = f3;
    issue_rs1    = a;
    issue_rs2    = b;
    issue_tag    = t;
    tick();
    issue_valid  = 1'b0;
    issue_rs1    = 64'hDEAD_BEEF_DEAD_BEEF;
    issue_rs2    = 64'h0BAD_F00D_0BAD_F00D;
  endtask

  task automatic wait_wb(input string tag);
    int n = 0;
    while (!wb_valid && n < 100) begin
      tick();
      n++;
    end
    chk(tag, wb_valid, 1'b1);
  endtask

  task automatic consume(input string tag);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk(tag, issue_ready, 1'b1);
  endtask

  task automatic watch_no_wb(input int cycles, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (wb_valid) seen = 1'b1;
    end
    chk(tag, seen, 1'b0);
  endtask

  initial begin
    reset = 1'b0; issue_valid = 1'b0; issue_funct3 = 3'd0;
    issue_rs1 = '0; issue_rs2 = '0; issue_tag = '0; kill = 1'b0;
    md_req_ready = 1'b1; wb_ready = 1'b0; md_resp_result = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_issue_ready", issue_ready, 1'b1);
    chk("rst_req_valid", md_req_valid, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_wb_result", wb_result, 64'h0);
    chk("rst_wb_tag", wb_tag, 5'd0);

    // MUL {3,-2} x {5,7}: exact latency and field decode
    md_resp_result = 64'h0000000F_FFFFFFF2;
    issue(3'd0, 64'h00000003_FFFFFFFE, 64'h00000005_00000007, 5'd9);
    chk("mul_req_valid", md_req_valid, 1'b1);
    chk("mul_op", md_req_op, 2'd0);
    chk("mul_sel", md_req_out_sel, 2'd0);
    chk("mul_s1", md_req_in_1_signed, 1'b0);
    chk("mul_s2", md_req_in_2_signed, 1'b0);
    chk("mul_in1", md_req_in_1, 64'h00000003_FFFFFFFE);
    chk("mul_in2", md_req_in_2, 64'h00000005_00000007);
    chk("mul_issue_ready", issue_ready, 1'b0);
    chk("mul_busy", busy, 1'b1);
    repeat (34) tick();
    chk("mul_wb_early", wb_valid, 1'b0);
    tick();
    chk("mul_wb_t36", wb_valid, 1'b1);
    chk("mul_result", wb_result, 64'h0000000F_FFFFFFF2);
    chk("mul_tag", wb_tag, 5'd9);
    consume("mul_done");
    chk("mul_wb_clear", wb_valid, 1'b0);

    // MULHSU decode
    md_resp_result = 64'h11111111_22222222;
    issue(3'd2, 64'h1, 64'h2, 5'd1);
    chk("mulhsu_op", md_req_op, 2'd0);
    chk("mulhsu_sel", md_req_out_sel, 2'd1);
    chk("mulhsu_s1", md_req_in_1_signed, 1'b1);
    chk("mulhsu_s2", md_req_in_2_signed, 1'b0);
    wait_wb("mulhsu_wb");
    consume("mulhsu_done");

    // REMU decode
    issue(3'd7, 64'h5, 64'h3, 5'd2);
    chk("remu_op", md_req_op, 2'd2);
    chk("remu_sel", md_req_out_sel, 2'd2);
    chk("remu_s1", md_req_in_1_signed, 1'b0);
    chk("remu_s2", md_req_in_2_signed, 1'b0);
    wait_wb("remu_wb");
    consume("remu_done");

    // DIV with a zero divisor lane: unit result passes through untouched
    md_resp_result = 64'hFFFFFFFF_00000003;
    issue(3'd4, 64'h00000007_00000009, 64'h00000000_00000003, 5'd4);
    chk("div_op", md_req_op, 2'd1);
    chk("div_sel", md_req_out_sel, 2'd0);
    chk("div_s1", md_req_in_1_signed, 1'b1);
    chk("div_s2", md_req_in_2_signed, 1'b1);
    wait_wb("div_wb");
    chk("div_result", wb_result, 64'hFFFFFFFF_00000003);
    chk("div_tag", wb_tag, 5'd4);
    consume("div_done");

    // req_ready low for 10 cycles, handshake on cycle 11
    md_req_ready = 1'b0;
    issue(3'd3, 64'hA5A5A5A5_5A5A5A5A, 64'h01234567_89ABCDEF, 5'd3);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", md_req_valid, 1'b1);
      chk("stall_in1", md_req_in_1, 64'hA5A5A5A5_5A5A5A5A);
      chk("stall_in2", md_req_in_2, 64'h01234567_89ABCDEF);
      chk("stall_sel", md_req_out_sel, 2'd1);
      tick();
    end
    chk("stall_c11_valid", md_req_valid, 1'b1);
    md_req_ready = 1'b1;
    tick();
    chk("stall_hs_gone", md_req_valid, 1'b0);
    chk("stall_hs_busy", busy, 1'b1);
    wait_wb("stall_wb");
    consume("stall_done");

    // kill at cycle 5 of S_REQ without handshake: request abandoned
    md_req_ready = 1'b0;
    issue(3'd0, 64'h7, 64'h8, 5'd5);
    repeat (4) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kreq_ready", issue_ready, 1'b1);
    chk("kreq_req_valid", md_req_valid, 1'b0);
    md_req_ready = 1'b1;
    watch_no_wb(40, "kreq_no_wb");

    // kill during S_WAIT: response consumed silently
    issue(3'd0, 64'h7, 64'h8, 5'd6);
    repeat (4) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kwait_busy", busy, 1'b1);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 29; i++) begin
        tick();
        if (wb_valid) seen = 1'b1;
      end
      chk("kwait_no_wb", seen, 1'b0);
    end
    chk("kwait_ready_t35", issue_ready, 1'b0);
    tick();
    chk("kwait_ready_t36", issue_ready, 1'b1);
    chk("kwait_wb_t36", wb_valid, 1'b0);

    // kill coincident with md_resp_valid
    issue(3'd0, 64'h7, 64'h8, 5'd7);
    repeat (34) tick();
    chk("kco_busy_t35", busy, 1'b1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kco_ready", issue_ready, 1'b1);
    chk("kco_wb", wb_valid, 1'b0);
    watch_no_wb(5, "kco_no_wb");

    // kill beats wb_ready in S_WB
    issue(3'd1, 64'h7, 64'h8, 5'd8);
    wait_wb("kwb_wb");
    kill = 1'b1; wb_ready = 1'b1;
    tick();
    kill = 1'b0; wb_ready = 1'b0;
    chk("kwb_wb_clear", wb_valid, 1'b0);
    chk("kwb_ready", issue_ready, 1'b1);

    // wb_ready low for 20 cycles while a new instruction waits
    md_resp_result = 64'hCAFEF00D_12345678;
    issue(3'd5, 64'h9, 64'h3, 5'd17);
    wait_wb("wbs_wb");
    issue_valid = 1'b1; issue_funct3 = 3'd6; issue_tag = 5'd30;
    for (int i = 0; i < 20; i++) begin
      chk("wbs_valid", wb_valid, 1'b1);
      chk("wbs_result", wb_result, 64'hCAFEF00D_12345678);
      chk("wbs_tag", wb_tag, 5'd17);
      chk("wbs_issue_ready", issue_ready, 1'b0);
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0; issue_valid = 1'b0;
    chk("wbs_idle", issue_ready, 1'b1);
    chk("wbs_no_bypass", md_req_valid, 1'b0);

    // Watchdog: unit never responds
    silent = 1'b1;
    issue(3'd0, 64'h1, 64'h1, 5'd11);
    repeat (64) tick();
    chk("to_before", timeout_err, 1'b0);
    chk("to_busy_before", busy, 1'b1);
    tick();
    chk("to_flag", timeout_err, 1'b1);
    chk("to_idle", busy, 1'b0);
    chk("to_ready", issue_ready, 1'b1);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick();
    chk("to_late_wb", wb_valid, 1'b0);
    chk("to_late_busy", busy, 1'b0);
    chk("to_sticky", timeout_err, 1'b1);
    silent = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("to_rst_clear", timeout_err, 1'b0);
    chk("to_rst_result", wb_result, 64'h0);
    chk("to_rst_tag", wb_tag, 5'd0);

    // Reset mid-operation
    issue(3'd0, 64'h2, 64'h2, 5'd12);
    repeat (5) tick();
    chk("mrst_busy_before", busy, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_req_valid", md_req_valid, 1'b0);
    chk("mrst_tag", wb_tag, 5'd0);
    watch_no_wb(40, "mrst_no_wb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xvec2_md_requester.md
Name: xvec2_md_requester

Overview:
- Pipeline-side initiator for the xvec2 vector multiply/divide unit.
- Accepts one decoded RV32M instruction (funct3, two packed vector operands, destination tag) from the execute stage.
- Translates funct3 into op, operand-signedness and output-select fields, then drives the unit's req_valid/req_ready handshake.
- Captures the unit's single-cycle resp_valid pulse and presents the result to writeback under a valid/ready handshake, with pipeline kill and a response watchdog.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in S_WAIT before the watchdog fires; must exceed unit latency (34).
- TAG_WIDTH, 5: width of the destination register tag carried alongside the request.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset (reset==0 resets on rising clk)
- issue_valid  input  1  execute stage presents an M-extension instruction
- issue_ready  output  1  requester can accept an instruction
- issue_funct3  input  3  RV32M funct3
- issue_rs1  input  `VEC_XPR_LEN  packed lane operands 1
- issue_rs2  input  `VEC_XPR_LEN  packed lane operands 2
- issue_tag  input  TAG_WIDTH  destination tag
- kill  input  1  pipeline flush; abandons the current instruction
- md_req_valid  output  1  to unit req_valid
- md_req_ready  input  1  from unit req_ready
- md_req_op  output  `MD_OP_WIDTH  to unit req_op
- md_req_out_sel  output  `MD_OUT_SEL_WIDTH  to unit req_out_sel
- md_req_in_1_signed  output  1  to unit
- md_req_in_2_signed  output  1  to unit
- md_req_in_1  output  `VEC_XPR_LEN  to unit
- md_req_in_2  output  `VEC_XPR_LEN  to unit
- md_resp_valid  input  1  single-cycle pulse from unit (no back-pressure)
- md_resp_result  input  `VEC_XPR_LEN  unit result
- wb_valid  output  1  result available to writeback
- wb_ready  input  1  writeback consumes the result
- wb_result  output  `VEC_XPR_LEN  captured result
- wb_tag  output  TAG_WIDTH  tag of the result
- busy  output  1  state != S_IDLE
- timeout_err  output  1  sticky watchdog flag

Behaviour:
- States: S_IDLE, S_REQ, S_WAIT, S_WB.
- Reset values: state=S_IDLE; md_req_valid=0; wb_valid=0; timeout_err=0; busy=0; wb_result=0; wb_tag=0.
- Registered outputs are only: state, operands, op fields, tag, result, timeout_err, watchdog counter. issue_ready = (state==S_IDLE). md_req_valid = (state==S_REQ). wb_valid = (state==S_WB).
- S_IDLE: on issue_valid && !kill, register operands, tag and decoded fields; go to S_REQ. Otherwise stay. md_resp_valid is ignored in S_IDLE.
- Decode, funct3 -> op / out_sel / s1 / s2:
  - 0 MUL: MUL / LO / 0 / 0
  - 1 MULH: MUL / HI / 1 / 1
  - 2 MULHSU: MUL / HI / 1 / 0
  - 3 MULHU: MUL / HI / 0 / 0
  - 4 DIV: DIV / LO / 1 / 1
  - 5 DIVU: DIV / LO / 0 / 0
  - 6 REM: REM / REM / 1 / 1
  - 7 REMU: REM / REM / 0 / 0
- Decoded fields use the `MD_OP_* and `MD_OUT_* constants.
- S_REQ: hold all md_req_* outputs stable until md_req_ready. On handshake go to S_WAIT, clear the watchdog counter and clear discard.
- kill in S_REQ:
  - Without handshake that cycle: go to S_IDLE; no request is issued.
  - With handshake that cycle: go to S_WAIT with discard=1.
- S_WAIT: increment the watchdog counter each cycle. kill sets discard=1.
  - On md_resp_valid: capture md_resp_result into wb_result. If discard (including kill in the same cycle), go to S_IDLE; else go to S_WB.
  - If the counter reaches TIMEOUT_CYCLES-1 without a response: set timeout_err and go to S_IDLE. A late response is then ignored.
- S_WB: hold wb_result and wb_tag stable until wb_ready, then go to S_IDLE.
  - kill in S_WB: go to S_IDLE, result dropped; kill wins over wb_ready in the same cycle.
  - No new issue is accepted until the state is S_IDLE (no bypass from S_WB).
- Latency with an always-ready unit: issue accepted at cycle T, md_req_valid at T+1, md_resp_valid at T+35, wb_valid at T+36.
- Division-by-zero and overflow results pass through from the unit unmodified.
- timeout_err clears only on reset.
- Reset asserted mid-operation: return to S_IDLE next edge, all outputs to reset values. The unit is reset by the same signal.

Test Plan:
- MUL, lanes rs1={3,-2}, rs2={5,7}, unit model always ready -> md_req_op=MUL, out_sel=LO, signed=0/0; wb_valid at T+36 with result {15,0xFFFFFFF2}, wb_tag echoed.
- MULHSU and REMU issue -> fields MUL/HI/1/0 and REM/REM/0/0; DIV with rs2 lanes {0,3} -> result passed through unchanged.
- Unit req_ready low for 10 cycles -> md_req_valid and operands stable throughout; handshake on cycle 11; kill at cycle 5 of a second run -> no handshake, S_IDLE, no wb_valid.
- kill during S_WAIT, and kill coincident with md_resp_valid -> response consumed, wb_valid never asserts, issue_ready next cycle.
- wb_ready held low 20 cycles -> wb_valid, wb_result and wb_tag stable, issue_ready=0 throughout.
- Unit model never responds -> timeout_err=1 after TIMEOUT_CYCLES in S_WAIT, state S_IDLE, late resp ignored; reset=0 clears the flag.
